pipe_regfile: RTL and testbench



---
 rtl/pipe_regfile.sv | 69 ++++++
 tb/tb_pipe_regfile.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_regfile.sv
// pipe_regfile: multi-port register file with per-register write-pending scoreboard
module pipe_regfile #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NREAD = 2,
  parameter int WRITE_FIRST = 1,
  parameter int ZERO_REG = 1,
  parameter int MAXPEND = 3,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(MAXPEND + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [WIDTH-1:0]       wd,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd,
  output logic [NREAD-1:0]       rdy,
  input  logic                   iss_valid,
  input  logic [AW-1:0]          iss_addr,
  output logic                   iss_ready,
  output logic                   pend_any,
  output logic                   wb_err
);
  logic [WIDTH-1:0] rf [DEPTH];
  logic [CW-1:0] cnt [DEPTH];
  logic [CW-1:0] cnt_nxt [DEPTH];
  logic [DEPTH-1:0] inc, dec;
  logic wr_ok, iss_zero, iss_ok;
  // reset_n gating keeps bypass and readiness at reset values while held in reset
  assign wr_ok = we && reset_n && !(ZERO_REG != 0 && wa == '0);
  assign iss_zero = ZERO_REG != 0 && iss_addr == '0;
  assign iss_ready = cnt[iss_addr] != CW'(MAXPEND) || iss_zero;
  assign iss_ok = iss_valid && iss_ready && !iss_zero && reset_n;
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic zr, hit;
    assign a = ra[i*AW +: AW];
    assign zr = ZERO_REG != 0 && a == '0;
    assign hit = WRITE_FIRST != 0 && wr_ok && wa == a;
    assign rd[i*WIDTH +: WIDTH] = zr ? '0 : hit ? wd : rf[a];
    assign rdy[i] = zr || cnt[a] == '0 || (hit && cnt[a] == CW'(1));
  end
  for (genvar r = 0; r < DEPTH; r++) begin : g_cnt
    assign inc[r] = iss_ok && iss_addr == AW'(r);
    assign dec[r] = wr_ok && wa == AW'(r) && cnt[r] != '0;
  end
  always_comb begin
    pend_any = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      cnt_nxt[r] = (inc[r] && !dec[r]) ? cnt[r] + CW'(1) : (dec[r] && !inc[r]) ? cnt[r] - CW'(1) : cnt[r];
      pend_any = pend_any | (cnt[r] != '0);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        rf[r] <= '0;
        cnt[r] <= '0;
      end
      wb_err <= 1'b0;
    end else begin
      if (wr_ok) rf[wa] <= wd;
      if (wr_ok && cnt[wa] == '0) wb_err <= 1'b1;
      for (int r = 0; r < DEPTH; r++) cnt[r] <= cnt_nxt[r];
    end
  end
endmodule

// File: tb/tb_pipe_regfile.sv
// tb_pipe_regfile: directed checks of pipe_regfile with write-first and read-first instances
module tb_pipe_regfile;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic we = 1'b0;
  logic [4:0] wa = '0;
  logic [31:0] wd = '0;
  logic [4:0] ra0 = '0, ra1 = '0;
  logic iss_valid = 1'b0;
  logic [4:0] iss_addr = '0;
  logic [63:0] rd_a, rd_b;
  logic [1:0] rdy_a, rdy_b;
  logic ready_a, ready_b, pend_a, pend_b, err_a, err_b;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  pipe_regfile #(.WRITE_FIRST(1)) dut (
    .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd), .ra({ra1, ra0}),
    .rd(rd_a), .rdy(rdy_a), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .iss_ready(ready_a), .pend_any(pend_a), .wb_err(err_a));

  pipe_regfile #(.WRITE_FIRST(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd), .ra({ra1, ra0}),
    .rd(rd_b), .rdy(rdy_b), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .iss_ready(ready_b), .pend_any(pend_b), .wb_err(err_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; iss_valid = 1'b0; wa = '0; wd = '0; iss_addr = '0; ra0 = '0; ra1 = '0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    #1;
    tests++; if (rd_a !== 64'h0) begin fails++; $display("FAIL reset_rd got %h exp 0", rd_a); end
    tests++; if (rdy_a !== 2'b11) begin fails++; $display("FAIL reset_rdy got %b exp 11", rdy_a); end
    tests++; if (ready_a !== 1'b1) begin fails++; $display("FAIL reset_iss_ready got %b exp 1", ready_a); end
    tests++; if ({pend_a, err_a, pend_b, err_b} !== 4'b0) begin fails++; $display("FAIL reset_flags got %b exp 0000", {pend_a, err_a, pend_b, err_b}); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_clear();
    bit bad = 0;
    for (int r = 1; r < 32; r++) begin
      we = 1'b1; wa = 5'(r); wd = 32'hDEADBEEF;
      tick();
    end
    we = 1'b0; iss_valid = 1'b1; iss_addr = 5'd3; ra0 = 5'd31;
    tick();
    iss_valid = 1'b0;
    tests++; if (rd_a[31:0] !== 32'hDEADBEEF) begin fails++; $display("FAIL clear_pre_r31 got %h exp deadbeef", rd_a[31:0]); end
    tests++; if ({pend_a, err_a} !== 2'b11) begin fails++; $display("FAIL clear_pre_flags got %b exp 11", {pend_a, err_a}); end
    #2;
    reset_n = 1'b0;
    #1;
    tests++; if ({pend_a, err_a, pend_b, err_b} !== 4'b0) begin fails++; $display("FAIL clear_async_flags got %b exp 0000", {pend_a, err_a, pend_b, err_b}); end
    for (int r = 0; r < 32; r++) begin
      ra0 = 5'(r);
      #0.1;
      if (rd_a[31:0] !== 32'h0 || rd_b[31:0] !== 32'h0) begin
        bad = 1;
        $display("FAIL clear_reg r%0d got %h/%h exp 0", r, rd_a[31:0], rd_b[31:0]);
      end
    end
    tests++; if (bad) fails++;
    reset_n = 1'b1;
    idle();
    tick();
  endtask

  task automatic test_bypass();
    do_reset();
    we = 1'b1; wa = 5'd5; wd = 32'h1234; ra0 = 5'd5;
    #1;
    tests++; if (rd_a[31:0] !== 32'h1234) begin fails++; $display("FAIL bypass_wf got %h exp 1234", rd_a[31:0]); end
    tests++; if (rd_b[31:0] !== 32'h0) begin fails++; $display("FAIL bypass_rf_old got %h exp 0", rd_b[31:0]); end
    tick();
    we = 1'b0;
    #1;
    tests++; if (rd_b[31:0] !== 32'h1234) begin fails++; $display("FAIL bypass_rf_new got %h exp 1234", rd_b[31:0]); end
  endtask

  task automatic test_zero();
    do_reset();
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF; iss_valid = 1'b1; iss_addr = 5'd0; ra0 = 5'd0;
    #1;
    tests++; if (rd_a[31:0] !== 32'h0) begin fails++; $display("FAIL zero_rd_same got %h exp 0", rd_a[31:0]); end
    tests++; if ({rdy_a[0], ready_a} !== 2'b11) begin fails++; $display("FAIL zero_rdy_ready got %b exp 11", {rdy_a[0], ready_a}); end
    tick();
    we = 1'b0; iss_valid = 1'b0;
    #1;
    tests++; if (rd_a[31:0] !== 32'h0 || rd_b[31:0] !== 32'h0) begin fails++; $display("FAIL zero_rd_after got %h/%h exp 0", rd_a[31:0], rd_b[31:0]); end
    tests++; if ({pend_a, err_a} !== 2'b00) begin fails++; $display("FAIL zero_flags got %b exp 00", {pend_a, err_a}); end
  endtask

  task automatic test_saturation();
    do_reset();
    iss_valid = 1'b1; iss_addr = 5'd7;
    repeat (3) tick();
    iss_valid = 1'b0; ra0 = 5'd7;
    #1;
    tests++; if (ready_a !== 1'b0) begin fails++; $display("FAIL sat_ready_r7 got %b exp 0", ready_a); end
    tests++; if (rdy_a[0] !== 1'b0) begin fails++; $display("FAIL sat_rdy_r7 got %b exp 0", rdy_a[0]); end
    tests++; if (pend_a !== 1'b1) begin fails++; $display("FAIL sat_pend got %b exp 1", pend_a); end
    iss_addr = 5'd8;
    #1;
    tests++; if (ready_a !== 1'b1) begin fails++; $display("FAIL sat_ready_r8 got %b exp 1", ready_a); end
    // saturated counter rejects the issue, so the write alone takes it from 3 to 2
    we = 1'b1; wa = 5'd7; wd = 32'h1; iss_valid = 1'b1; iss_addr = 5'd7;
    #1;
    tests++; if (ready_a !== 1'b0 || rdy_a[0] !== 1'b0) begin fails++; $display("FAIL sat_wr_iss got ready=%b rdy=%b exp 0 0", ready_a, rdy_a[0]); end
    tick();
    we = 1'b0; iss_valid = 1'b0;
    #1;
    tests++; if (ready_a !== 1'b1 || rdy_a[0] !== 1'b0) begin fails++; $display("FAIL sat_cnt2 got ready=%b rdy=%b exp 1 0", ready_a, rdy_a[0]); end
    we = 1'b1; wd = 32'h2;
    tick();
    we = 1'b0;
    #1;
    tests++; if (rdy_a[0] !== 1'b0) begin fails++; $display("FAIL sat_cnt1 got %b exp 0", rdy_a[0]); end
    we = 1'b1; wd = 32'h3;
    #1;
    tests++; if (rdy_a[0] !== 1'b1 || rdy_b[0] !== 1'b0) begin fails++; $display("FAIL sat_last_byp got %b/%b exp 1/0", rdy_a[0], rdy_b[0]); end
    tick();
    we = 1'b0;
    #1;
    tests++; if (rdy_a[0] !== 1'b1 || pend_a !== 1'b0 || err_a !== 1'b0) begin fails++; $display("FAIL sat_drained got rdy=%b pend=%b err=%b exp 1 0 0", rdy_a[0], pend_a, err_a); end
    tests++; if (rd_a[31:0] !== 32'h3) begin fails++; $display("FAIL sat_data got %h exp 3", rd_a[31:0]); end
  endtask

  task automatic test_bypass_ready();
    do_reset();
    iss_valid = 1'b1; iss_addr = 5'd9;
    tick();
    iss_valid = 1'b0; ra1 = 5'd9;
    #1;
    tests++; if (rdy_a[1] !== 1'b0) begin fails++; $display("FAIL bypr_pending got %b exp 0", rdy_a[1]); end
    we = 1'b1; wa = 5'd9; wd = 32'hA5;
    #1;
    tests++; if (rdy_a[1] !== 1'b1 || rd_a[63:32] !== 32'hA5) begin fails++; $display("FAIL bypr_wf got rdy=%b rd=%h exp 1 a5", rdy_a[1], rd_a[63:32]); end
    tests++; if (rdy_b[1] !== 1'b0) begin fails++; $display("FAIL bypr_rf got %b exp 0", rdy_b[1]); end
    tick();
    we = 1'b0;
    #1;
    tests++; if (rdy_b[1] !== 1'b1 || rd_b[63:32] !== 32'hA5 || err_a !== 1'b0) begin fails++; $display("FAIL bypr_after got rdy=%b rd=%h err=%b exp 1 a5 0", rdy_b[1], rd_b[63:32], err_a); end
  endtask

  task automatic test_error();
    do_reset();
    we = 1'b1; wa = 5'd12; wd = 32'h77;
    tick();
    we = 1'b0; ra0 = 5'd12;
    #1;
    tests++; if (err_a !== 1'b1 || err_b !== 1'b1) begin fails++; $display("FAIL err_set got %b/%b exp 1/1", err_a, err_b); end
    tests++; if (rd_a[31:0] !== 32'h77) begin fails++; $display("FAIL err_data got %h exp 77", rd_a[31:0]); end
    repeat (3) tick();
    tests++; if (err_a !== 1'b1) begin fails++; $display("FAIL err_sticky got %b exp 1", err_a); end
    reset_n = 1'b0;
    #1;
    tests++; if (err_a !== 1'b0) begin fails++; $display("FAIL err_clear got %b exp 0", err_a); end
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_clear();
    test_bypass();
    test_zero();
    test_saturation();
    test_bypass_ready();
    test_error();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
